ps2_key_event_ctrl: RTL and testbench

PS2_KEY_EVENT_CTRL -- requirements
Module: ps2_key_event_ctrl

---
 rtl/ps2_pkg.sv | 49 ++++
 rtl/ps2_event_fifo.sv | 50 +++++
 rtl/ps2_key_event_ctrl.sv | 107 ++++++++++
 tb/tb_ps2_key_event_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants and types for the PS/2 key event controller.
//   - Prefix bytes (extended 0xE0, break 0xF0)
//   - Codes silently discarded when no prefix is pending
//   - The eight tracked keys (code + extended flag), bit order matches key_state
//   - Parser FSM state encoding
package ps2_pkg;

  localparam logic [7:0] PrefixExt = 8'hE0;
  localparam logic [7:0] PrefixBrk = 8'hF0;

  localparam int unsigned NumDiscard = 8;
  localparam logic [NumDiscard*8-1:0] DiscardCodes =
    {8'hFF, 8'hFE, 8'hFD, 8'hFC, 8'hFA, 8'hEE, 8'hAA, 8'h00};

  // Entry i lives in bits [i*8 +: 8]: W A S D Up Left Down Right.
  localparam int unsigned NumKeys = 8;
  localparam logic [NumKeys*8-1:0] KeyCodes =
    {8'h74, 8'h72, 8'h6B, 8'h75, 8'h23, 8'h1B, 8'h1C, 8'h1D};
  localparam logic [NumKeys-1:0] KeyExt = 8'b1111_0000;

  typedef enum logic [1:0] {
    StIdle,
    StExt,
    StBrk,
    StExtBrk
  } ps2_state_e;

  // Event entry layout: {ext, break, code}.
  localparam int unsigned EventWidth = 10;

  function automatic logic is_discard(input logic [7:0] code);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NumDiscard; i++) begin
      if (DiscardCodes[i*8 +: 8] == code) hit = 1'b1;
    end
    return hit;
  endfunction

  // One-hot match of an event against the tracked-key table.
  function automatic logic [NumKeys-1:0] key_match(input logic [7:0] code, input logic ext);
    logic [NumKeys-1:0] m;
    for (int i = 0; i < NumKeys; i++) begin
      m[i] = (KeyCodes[i*8 +: 8] == code) && (KeyExt[i] == ext);
    end
    return m;
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo: small synchronous FIFO holding parsed key events.
//   clk, rst   : clock, asynchronous active-high reset
//   push, wdata: write request and entry; accepted when not full or when popping
//   pop        : read request; ignored when empty
//   rdata      : head entry, forced to zero while empty
//   full, empty: occupancy flags
module ps2_event_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  // Extra MSB distinguishes full from empty when the addresses coincide.
  logic [AddrW:0]   wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign do_pop  = pop && !empty;
  // When full, the slot being written is the head being popped this same edge.
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr_q[AddrW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[AddrW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ps2_key_event_ctrl.sv
// ps2_key_event_ctrl: turns raw PS/2 scan bytes into make/break key events.
//   CLOCK_50, reset        : clock, asynchronous active-high reset
//   scan_ready, scan_code  : one-cycle byte strobe from the scancode driver
//   ev_valid/ev_ready      : event stream handshake (pop on both high)
//   ev_code/ev_ext/ev_break: head event, prefixes stripped
//   key_state              : held bitmap of W A S D Up Left Down Right
//   last_code              : last raw byte seen (for the HEX display)
//   overflow, proto_err    : sticky flags, cleared by clr_flags
module ps2_key_event_ctrl
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       scan_ready,
  input  logic [7:0] scan_code,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_break,
  output logic [7:0] key_state,
  output logic [7:0] last_code,
  output logic       overflow,
  output logic       proto_err,
  input  logic       clr_flags
);

  ps2_state_e           state_q, state_d;
  logic                 ev_done, perr_set, ovf_set;
  logic                 cur_ext, cur_brk;
  logic                 fifo_full, fifo_empty, pop;
  logic [EventWidth-1:0] head;

  assign cur_ext = (state_q == StExt) || (state_q == StExtBrk);
  assign cur_brk = (state_q == StBrk) || (state_q == StExtBrk);

  always_comb begin
    state_d  = state_q;
    ev_done  = 1'b0;
    perr_set = 1'b0;
    if (scan_ready) begin
      if (scan_code == PrefixExt) begin
        perr_set = (state_q != StIdle);
        state_d  = StExt;
      end else if (scan_code == PrefixBrk) begin
        unique case (state_q)
          StIdle:  state_d  = StBrk;
          StExt:   state_d  = StExtBrk;
          default: perr_set = 1'b1;
        endcase
      end else if (!(state_q == StIdle && is_discard(scan_code))) begin
        ev_done = 1'b1;
        state_d = StIdle;
      end
    end
  end

  assign pop     = ev_valid && ev_ready;
  assign ovf_set = ev_done && fifo_full && !pop;

  ps2_event_fifo #(
    .Depth(FIFO_DEPTH),
    .Width(EventWidth)
  ) u_fifo (
    .clk  (CLOCK_50),
    .rst  (reset),
    .push (ev_done),
    .pop  (pop),
    .wdata({cur_ext, cur_brk, scan_code}),
    .rdata(head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign ev_valid = !fifo_empty;
  assign ev_ext   = head[9];
  assign ev_break = head[8];
  assign ev_code  = head[7:0];

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      key_state <= '0;
      last_code <= '0;
      overflow  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state_q <= state_d;
      if (scan_ready) last_code <= scan_code;
      // Key tracking follows the byte stream even when the FIFO drops the event.
      if (ev_done) begin
        if (cur_brk) key_state <= key_state & ~key_match(scan_code, cur_ext);
        else         key_state <= key_state |  key_match(scan_code, cur_ext);
      end
      // Set is written last so it wins over a simultaneous clear.
      if (clr_flags) begin
        overflow  <= 1'b0;
        proto_err <= 1'b0;
      end
      if (ovf_set)  overflow  <= 1'b1;
      if (perr_set) proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Randomised scoreboard bench for ps2_key_event_ctrl. The reference model tracks
// pending prefixes as two flags and the FIFO as a queue of expected events.
module tb_ps2_key_event_ctrl;

  localparam int unsigned Depth = 4;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       scan_ready = 1'b0;
  logic [7:0] scan_code = 8'h00;
  logic       ev_valid;
  logic       ev_ready = 1'b0;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_break;
  logic [7:0] key_state;
  logic [7:0] last_code;
  logic       overflow;
  logic       proto_err;
  logic       clr_flags = 1'b0;

  ps2_key_event_ctrl #(
    .FIFO_DEPTH(Depth)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .scan_ready(scan_ready),
    .scan_code(scan_code),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_code  (ev_code),
    .ev_ext   (ev_ext),
    .ev_break (ev_break),
    .key_state(key_state),
    .last_code(last_code),
    .overflow (overflow),
    .proto_err(proto_err),
    .clr_flags(clr_flags)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [9:0] exp_q[$];
  bit         m_ext, m_brk, m_ovf, m_perr;
  logic [7:0] m_keys, m_last;
  logic [7:0] key_tab [8] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h75, 8'h6B, 8'h72, 8'h74};
  bit         key_ext_tab [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
  logic [7:0] pool [14] = '{8'hE0, 8'hF0, 8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h75, 8'h6B,
                            8'h72, 8'h74, 8'hAA, 8'hFA, 8'hE1, 8'h00};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_junk(input logic [7:0] b);
    return b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};
  endfunction

  // Apply one received byte to the model; called right after the sampling edge,
  // when the monitor has already retired any event popped at that edge.
  task automatic model_byte(input logic [7:0] b);
    m_last = b;
    if (b == 8'hE0) begin
      if (m_ext || m_brk) m_perr = 1'b1;
      m_ext = 1'b1;
      m_brk = 1'b0;
    end else if (b == 8'hF0) begin
      if (m_brk) m_perr = 1'b1;
      else       m_brk  = 1'b1;
    end else if (m_ext || m_brk || !is_junk(b)) begin
      for (int i = 0; i < 8; i++) begin
        if (key_tab[i] == b && key_ext_tab[i] == m_ext) m_keys[i] = !m_brk;
      end
      if (exp_q.size() < Depth) exp_q.push_back({m_ext, m_brk, b});
      else                      m_ovf = 1'b1;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_ext  = 1'b0;
    m_brk  = 1'b0;
    m_ovf  = 1'b0;
    m_perr = 1'b0;
    m_keys = 8'h00;
    m_last = 8'h00;
  endtask

  // Called just after a posedge; returns just after the next one.
  task automatic step(input bit v, input logic [7:0] b, input bit rdy, input bit clr);
    scan_ready = v;
    scan_code  = b;
    ev_ready   = rdy;
    clr_flags  = clr;
    @(posedge CLOCK_50);
    if (clr) begin
      m_ovf  = 1'b0;
      m_perr = 1'b0;
    end
    if (v) model_byte(b);
    #1;
    scan_ready = 1'b0;
    clr_flags  = 1'b0;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, rdy, 1'b0);
  endtask

  task automatic send(input logic [7:0] b, input bit rdy);
    step(1'b1, b, rdy, 1'b0);
  endtask

  task automatic do_reset();
    #1;
    reset      = 1'b1;
    scan_ready = 1'b0;
    ev_ready   = 1'b0;
    clr_flags  = 1'b0;
    model_clear();
    repeat (2) @(posedge CLOCK_50);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: compares every cycle between active edges; pops on a handshake.
  always @(negedge CLOCK_50) begin
    check("ev_valid", 32'(ev_valid), 32'(exp_q.size() != 0));
    if (ev_valid && exp_q.size() != 0) begin
      check("ev_head", 32'({ev_ext, ev_break, ev_code}), 32'(exp_q[0]));
      if (ev_ready) void'(exp_q.pop_front());
    end
    check("key_state", 32'(key_state), 32'(m_keys));
    check("last_code", 32'(last_code), 32'(m_last));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("proto_err", 32'(proto_err), 32'(m_perr));
  end

  initial begin
    model_clear();
    @(posedge CLOCK_50);
    do_reset();
    check("reset_outputs", 32'({ev_valid, ev_ext, ev_break, ev_code, key_state, last_code,
                                overflow, proto_err}), 32'h0);

    // W make, then W break.
    send(8'h1D, 1'b0);
    idle(1, 1'b0);
    idle(2, 1'b1);
    send(8'hF0, 1'b0);
    send(8'h1D, 1'b0);
    idle(2, 1'b1);

    // Extended Up break, then extended make.
    send(8'hE0, 1'b1);
    send(8'hF0, 1'b1);
    send(8'h75, 1'b1);
    send(8'hE0, 1'b1);
    send(8'h75, 1'b1);
    idle(2, 1'b1);
    check("up_held", 32'(key_state), 32'h10);

    // Non-extended 0x75 must leave Up alone.
    send(8'hF0, 1'b1);
    send(8'h75, 1'b1);
    idle(2, 1'b1);

    // Five makes into a four-deep FIFO with no consumer.
    send(8'h1D, 1'b0);
    send(8'h1C, 1'b0);
    send(8'h1B, 1'b0);
    send(8'h23, 1'b0);
    send(8'hE0, 1'b0);
    send(8'h6B, 1'b0);
    idle(1, 1'b0);
    check("ovf_set", 32'(overflow), 32'h1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("ovf_clr", 32'(overflow), 32'h0);

    // Full FIFO: push and pop on the same edge.
    send(8'hE0, 1'b0);
    send(8'h72, 1'b1);
    idle(1, 1'b0);
    check("full_valid", 32'(ev_valid), 32'h1);
    check("full_no_ovf", 32'(overflow), 32'h0);
    idle(6, 1'b1);

    // Clear and set in the same cycle: set wins.
    send(8'h1D, 1'b0);
    send(8'h1C, 1'b0);
    send(8'h1B, 1'b0);
    send(8'h23, 1'b0);
    step(1'b1, 8'h2B, 1'b0, 1'b1);
    check("set_wins", 32'(overflow), 32'h1);
    idle(6, 1'b1);

    // Illegal prefix sequences.
    send(8'hF0, 1'b1);
    send(8'hF0, 1'b1);
    send(8'h1C, 1'b1);
    send(8'hE0, 1'b1);
    send(8'hE0, 1'b1);
    send(8'h74, 1'b1);
    idle(2, 1'b1);
    check("perr_set", 32'(proto_err), 32'h1);

    // Discarded codes, then reset mid-sequence.
    send(8'hAA, 1'b1);
    send(8'hFA, 1'b1);
    idle(1, 1'b1);
    check("discard_last", 32'(last_code), 32'hFA);
    send(8'hF0, 1'b1);
    do_reset();
    send(8'h1B, 1'b0);
    idle(3, 1'b1);

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] b;
      if ($urandom_range(0, 4) == 0) b = 8'($urandom);
      else b = pool[$urandom_range(0, 13)];
      if ($urandom_range(0, 599) == 0) do_reset();
      else step($urandom_range(0, 2) != 0, b, $urandom_range(0, 3) != 0,
                $urandom_range(0, 39) == 0);
    end

    idle(Depth + 4, 1'b1);
    check("drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
